// File: rtl/core_pkg.sv
// LETC core shared types and CSR address map.
// Privilege modes, counter CSR addresses and the decoded-access bundle.
package core_pkg;

  typedef enum logic [1:0] {
    PRV_U = 2'd0,
    PRV_S = 2'd1,
    PRV_M = 2'd3
  } prv_mode_t;

  localparam logic [11:0] CSR_SCOUNTEREN    = 12'h106;
  localparam logic [11:0] CSR_MCOUNTEREN    = 12'h306;
  localparam logic [11:0] CSR_MCOUNTINHIBIT = 12'h320;
  localparam logic [11:0] CSR_MHPMEVENT3    = 12'h323;
  localparam logic [11:0] CSR_MCYCLE        = 12'hB00;
  localparam logic [11:0] CSR_MINSTRET      = 12'hB02;
  localparam logic [11:0] CSR_MHPMCOUNTER3  = 12'hB03;
  localparam logic [11:0] CSR_MCYCLEH       = 12'hB80;
  localparam logic [11:0] CSR_CYCLE         = 12'hC00;
  localparam logic [11:0] CSR_CYCLEH        = 12'hC80;

  typedef enum logic [2:0] {
    CLS_NONE,
    CLS_SCEN,
    CLS_MCEN,
    CLS_MCFG,
    CLS_MCNT,
    CLS_UCNT
  } csr_cls_e;

  typedef struct packed {
    csr_cls_e   cls;
    logic       vld;
    logic       hi;
    logic [4:0] idx;
  } cnt_acc_t;

  function automatic logic [31:0] cnt_impl_mask(int unsigned num_hpm);
    logic [31:0] m;
    m = 32'h5;
    for (int i = 0; i < 29; i++)
      if (i < int'(num_hpm)) m[i+3] = 1'b1;
    return m;
  endfunction

endpackage

// File: rtl/core_csr_counter.sv
// One CNT_WIDTH counter with per-half 32-bit writes.
// A write to either half wins over the increment for that cycle.
module core_csr_counter #(
  parameter int unsigned W = 64
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc_en,
  input  logic         wr_lo,
  input  logic         wr_hi,
  input  logic [31:0]  wr_data,
  output logic [W-1:0] cnt,
  output logic         wrap
);

  logic [W-1:0] cnt_q, cnt_d;
  logic [63:0]  lo_ld, hi_ld;

  always_comb begin
    lo_ld        = 64'(cnt_q);
    lo_ld[31:0]  = wr_data;
    hi_ld        = 64'(cnt_q);
    hi_ld[63:32] = wr_data;
    wrap         = 1'b0;
    cnt_d        = cnt_q;
    if (wr_lo) begin
      cnt_d = W'(lo_ld);
    end else if (wr_hi) begin
      cnt_d = W'(hi_ld);
    end else if (inc_en) begin
      cnt_d = cnt_q + 1'b1;
      wrap  = &cnt_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/core_csr_counters.sv
// Counter/timer CSR bank: mcycle, minstret, mhpmcounters,
// their event selectors, inhibit and enable masks.
module core_csr_counters
  import core_pkg::*;
#(
  parameter int unsigned NUM_HPM    = 4,
  parameter int unsigned CNT_WIDTH  = 64,
  parameter int unsigned NUM_EVENTS = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [11:0]           csr_sel,
  input  logic                  csr_rd_en,
  input  logic                  csr_wr_en,
  input  logic [31:0]           csr_wr_data,
  input  prv_mode_t             prv_mode,
  output logic                  csr_hit,
  output logic [31:0]           csr_rd_data,
  output logic                  csr_illegal,
  input  logic                  event_retire,
  input  logic [NUM_EVENTS-1:0] hpm_events,
  output logic                  hpm_ovf_pending
);

  localparam int unsigned NCNT = 2 + NUM_HPM;
  localparam logic [31:0] IMPL = cnt_impl_mask(NUM_HPM);

  cnt_acc_t acc;
  logic     ill, wr_ok, cnt_wr;

  logic [31:0] inh_q, inh_d;
  logic [31:0] mcen_q, mcen_d;
  logic [31:0] scen_q, scen_d;
  logic [7:0]  evt_sel_q [NUM_HPM];
  logic [7:0]  evt_sel_d [NUM_HPM];
  logic [NUM_HPM-1:0] of_q, of_d;

  logic [CNT_WIDTH-1:0] cnt_w [NCNT];
  logic [NCNT-1:0]      wrap_w;
  logic [63:0]          cnt_ext [32];
  logic [255:0]         ev_ext;

  // Selector 0 maps to a hard zero so it can never count.
  assign ev_ext = 256'({hpm_events, 1'b0});

  always_comb begin
    acc     = '0;
    acc.idx = csr_sel[4:0];
    acc.hi  = csr_sel[7];
    acc.vld = (csr_sel[6:5] == 2'b00);
    unique case (1'b1)
      csr_sel == CSR_SCOUNTEREN: acc.cls = CLS_SCEN;
      csr_sel == CSR_MCOUNTEREN: acc.cls = CLS_MCEN;
      csr_sel[11:5] == CSR_MCOUNTINHIBIT[11:5]:
        acc.cls = CLS_MCFG;
      csr_sel[11:8] == CSR_MCYCLE[11:8] &&
        csr_sel[7:0] < 8'hA0:
        acc.cls = CLS_MCNT;
      csr_sel[11:8] == CSR_CYCLE[11:8] &&
        csr_sel[7:0] < 8'hA0:
        acc.cls = CLS_UCNT;
      default: acc.cls = CLS_NONE;
    endcase
  end

  always_comb begin
    ill = 1'b0;
    case (acc.cls)
      CLS_SCEN: ill = (prv_mode == PRV_U);
      CLS_MCEN, CLS_MCFG, CLS_MCNT:
        ill = (prv_mode != PRV_M);
      CLS_UCNT:
        ill = csr_wr_en
            | ((prv_mode != PRV_M) & ~mcen_q[acc.idx])
            | ((prv_mode == PRV_U) & ~scen_q[acc.idx]);
      default: ill = 1'b0;
    endcase
  end

  assign csr_hit     = (acc.cls != CLS_NONE);
  assign csr_illegal = ill & csr_hit & (csr_rd_en | csr_wr_en);
  assign wr_ok       = csr_wr_en & csr_hit & ~csr_illegal;
  assign cnt_wr      = wr_ok & (acc.cls == CLS_MCNT) & acc.vld;

  for (genvar k = 0; k < NCNT; k++) begin : g_cnt
    localparam int unsigned IDX = (k == 0) ? 0 : (k == 1) ? 2 : k + 1;
    logic inc;
    if (k == 0) begin : g_cyc
      assign inc = ~inh_q[0];
    end else if (k == 1) begin : g_ret
      assign inc = event_retire & ~inh_q[2];
    end else begin : g_hpm
      assign inc = ev_ext[evt_sel_q[k-2]] & ~inh_q[IDX];
    end
    core_csr_counter #(.W(CNT_WIDTH)) u_cnt (
      .clk     (clk),
      .rst_n   (rst_n),
      .inc_en  (inc),
      .wr_lo   (cnt_wr & ~acc.hi & (acc.idx == 5'(IDX))),
      .wr_hi   (cnt_wr &  acc.hi & (acc.idx == 5'(IDX))),
      .wr_data (csr_wr_data),
      .cnt     (cnt_w[k]),
      .wrap    (wrap_w[k])
    );
  end

  always_comb begin
    inh_d     = inh_q;
    mcen_d    = mcen_q;
    scen_d    = scen_q;
    evt_sel_d = evt_sel_q;
    of_d      = of_q;
    if (wr_ok) begin
      case (acc.cls)
        CLS_SCEN: scen_d = csr_wr_data & IMPL;
        CLS_MCEN: mcen_d = csr_wr_data & IMPL;
        CLS_MCFG:
          if (acc.idx == 5'd0) inh_d = csr_wr_data & IMPL;
        default: ;
      endcase
    end
    // A wrap in the same cycle as a software OF clear keeps OF set.
    for (int j = 0; j < int'(NUM_HPM); j++) begin
      if (wr_ok && acc.cls == CLS_MCFG && acc.idx == 5'(j + 3)) begin
        evt_sel_d[j] = csr_wr_data[7:0];
        of_d[j]      = csr_wr_data[31];
      end
      if (wrap_w[j+2]) of_d[j] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inh_q     <= '0;
      mcen_q    <= '0;
      scen_q    <= '0;
      evt_sel_q <= '{default: '0};
      of_q      <= '0;
    end else begin
      inh_q     <= inh_d;
      mcen_q    <= mcen_d;
      scen_q    <= scen_d;
      evt_sel_q <= evt_sel_d;
      of_q      <= of_d;
    end
  end

  always_comb begin
    for (int i = 0; i < 32; i++) cnt_ext[i] = '0;
    cnt_ext[0] = 64'(cnt_w[0]);
    cnt_ext[2] = 64'(cnt_w[1]);
    for (int j = 0; j < int'(NUM_HPM); j++)
      cnt_ext[j+3] = 64'(cnt_w[j+2]);
  end

  always_comb begin
    csr_rd_data = '0;
    case (acc.cls)
      CLS_SCEN: csr_rd_data = scen_q;
      CLS_MCEN: csr_rd_data = mcen_q;
      CLS_MCFG: begin
        if (acc.idx == 5'd0) csr_rd_data = inh_q;
        for (int j = 0; j < int'(NUM_HPM); j++)
          if (acc.idx == 5'(j + 3))
            csr_rd_data = {of_q[j], 23'b0, evt_sel_q[j]};
      end
      CLS_MCNT, CLS_UCNT:
        if (acc.vld)
          csr_rd_data = acc.hi ? cnt_ext[acc.idx][63:32]
                               : cnt_ext[acc.idx][31:0];
      default: csr_rd_data = '0;
    endcase
  end

  assign hpm_ovf_pending = |of_q;

endmodule

// File: tb/tb_core_csr_counters.sv
// Bench for core_csr_counters: directed checks plus random
// traffic scored against a behavioural model of the CSR bank.
module tb_core_csr_counters;
  import core_pkg::*;

  localparam int NH = 4;
  localparam int CW = 40;
  localparam int NE = 8;
  localparam logic [63:0] MASK = (64'd1 << CW) - 64'd1;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [11:0]     csr_sel = '0;
  logic            csr_rd_en = 1'b0;
  logic            csr_wr_en = 1'b0;
  logic [31:0]     csr_wr_data = '0;
  prv_mode_t       prv_mode = PRV_M;
  logic            csr_hit;
  logic [31:0]     csr_rd_data;
  logic            csr_illegal;
  logic            event_retire = 1'b0;
  logic [NE-1:0]   hpm_events = '0;
  logic            hpm_ovf_pending;

  always #5 clk = ~clk;

  core_csr_counters #(
    .NUM_HPM(NH), .CNT_WIDTH(CW), .NUM_EVENTS(NE)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .csr_sel         (csr_sel),
    .csr_rd_en       (csr_rd_en),
    .csr_wr_en       (csr_wr_en),
    .csr_wr_data     (csr_wr_data),
    .prv_mode        (prv_mode),
    .csr_hit         (csr_hit),
    .csr_rd_data     (csr_rd_data),
    .csr_illegal     (csr_illegal),
    .event_retire    (event_retire),
    .hpm_events      (hpm_events),
    .hpm_ovf_pending (hpm_ovf_pending)
  );

  int unsigned n_pass = 0;
  int unsigned n_total = 0;
  bit run = 1'b0;

  task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  // Behavioural model state: counters indexed by CSR number.
  logic [63:0] m_cnt [32];
  logic [31:0] m_evt [32];
  logic [31:0] m_inh, m_mcen, m_scen;

  function automatic bit impl(int i);
    return i == 0 || i == 2 || (i >= 3 && i < 3 + NH);
  endfunction

  function automatic logic [31:0] impl_mask();
    logic [31:0] m = '0;
    for (int i = 0; i < 32; i++) m[i] = impl(i);
    return m;
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 32; i++) begin
      m_cnt[i] = '0;
      m_evt[i] = '0;
    end
    m_inh = '0; m_mcen = '0; m_scen = '0;
  endtask

  function automatic bit is_hit(logic [11:0] a);
    return a == 12'h106 || a == 12'h306 ||
           (a >= 12'h320 && a <= 12'h33F) ||
           (a >= 12'hB00 && a <= 12'hB9F) ||
           (a >= 12'hC00 && a <= 12'hC9F);
  endfunction

  function automatic bit is_ill(logic [11:0] a, bit rd, bit wr,
                                prv_mode_t p);
    int i;
    if (!(rd || wr) || !is_hit(a)) return 1'b0;
    i = int'(a[4:0]);
    if (a[11:8] == 4'hC)
      return wr || (p != PRV_M && !m_mcen[i]) ||
             (p == PRV_U && !m_scen[i]);
    if (a == 12'h106) return p == PRV_U;
    return p != PRV_M;
  endfunction

  function automatic logic [31:0] m_read(logic [11:0] a);
    int off;
    if (a == 12'h106) return m_scen;
    if (a == 12'h306) return m_mcen;
    if (a == 12'h320) return m_inh;
    if (a >= 12'h321 && a <= 12'h33F) return m_evt[int'(a - 12'h320)];
    if (a[11:8] == 4'hB || a[11:8] == 4'hC) begin
      off = int'(a[7:0]);
      if (off < 32) return m_cnt[off][31:0];
      if (off >= 128 && off < 160) return m_cnt[off-128][63:32];
    end
    return '0;
  endfunction

  function automatic logic [31:0] ovf_exp();
    logic r = 1'b0;
    for (int i = 0; i < 32; i++) r |= m_evt[i][31];
    return 32'(r);
  endfunction

  task automatic m_step(bit ill);
    logic [63:0] nc [32];
    logic [31:0] nev [32];
    logic [11:0] a;
    logic [31:0] d;
    bit ok, inc, wrapf;
    int e;
    a  = csr_sel;
    d  = csr_wr_data;
    ok = csr_wr_en && is_hit(a) && !ill;
    nc = m_cnt;
    nev = m_evt;
    for (int i = 0; i < 32; i++) begin
      if (!impl(i)) continue;
      wrapf = 1'b0;
      inc   = 1'b0;
      if (i == 0) inc = !m_inh[0];
      else if (i == 2) inc = event_retire && !m_inh[2];
      else begin
        e = int'(m_evt[i][7:0]);
        if (e >= 1 && e <= NE) inc = hpm_events[e-1] && !m_inh[i];
      end
      if (ok && a == 12'hB00 + 12'(i))
        nc[i] = {m_cnt[i][63:32], d};
      else if (ok && a == 12'hB80 + 12'(i))
        nc[i] = {d, m_cnt[i][31:0]} & MASK;
      else if (inc) begin
        nc[i] = (m_cnt[i] + 64'd1) & MASK;
        wrapf = (nc[i] == 64'd0);
      end
      if (i >= 3 && ok && a == 12'h320 + 12'(i))
        nev[i] = d & 32'h800000FF;
      if (i >= 3 && wrapf) nev[i][31] = 1'b1;
    end
    if (ok && a == 12'h320) m_inh  = d & impl_mask();
    if (ok && a == 12'h306) m_mcen = d & impl_mask();
    if (ok && a == 12'h106) m_scen = d & impl_mask();
    m_cnt = nc;
    m_evt = nev;
  endtask

  bit c_ill;
  always @(negedge clk) begin
    #2;
    if (run && rst_n) begin
      c_ill = is_ill(csr_sel, csr_rd_en, csr_wr_en, prv_mode);
      chk("hit", 32'(csr_hit), 32'(is_hit(csr_sel)));
      chk("illegal", 32'(csr_illegal), 32'(c_ill));
      if (is_hit(csr_sel))
        chk("rd_data", csr_rd_data, m_read(csr_sel));
      chk("ovf", 32'(hpm_ovf_pending), ovf_exp());
      m_step(c_ill);
    end
  end

  task automatic drive(logic [11:0] a, bit rd, bit wr,
                       logic [31:0] d, prv_mode_t p);
    csr_sel = a; csr_rd_en = rd; csr_wr_en = wr;
    csr_wr_data = d; prv_mode = p;
  endtask

  task automatic wr_m(logic [11:0] a, logic [31:0] d);
    drive(a, 1'b0, 1'b1, d, PRV_M);
    @(negedge clk);
  endtask

  task automatic rd_chk(logic [11:0] a, prv_mode_t p,
                        logic [31:0] exp, string name);
    drive(a, 1'b1, 1'b0, '0, p);
    #1 chk(name, csr_rd_data, exp);
    @(negedge clk);
  endtask

  task automatic acc_ill(logic [11:0] a, bit wr, prv_mode_t p,
                         bit exp, string name);
    drive(a, !wr, wr, 32'h1234, p);
    #1 chk(name, 32'(csr_illegal), 32'(exp));
    @(negedge clk);
  endtask

  localparam logic [11:0] ADDRS [28] = '{
    12'hB00, 12'hB80, 12'hB02, 12'hB82, 12'hB03, 12'hB04, 12'hB05,
    12'hB06, 12'hB83, 12'hB86, 12'hB1F, 12'hB40, 12'hC00, 12'hC80,
    12'hC02, 12'hC03, 12'hC06, 12'hC50, 12'h320, 12'h323, 12'h324,
    12'h325, 12'h326, 12'h306, 12'h106, 12'h321, 12'h33F, 12'h7C0
  };

  initial begin
    int r;
    logic [31:0] d;
    m_reset();
    repeat (3) @(negedge clk);
    drive(12'hB00, 1'b1, 1'b0, '0, PRV_M);
    #1;
    chk("reset_ovf", 32'(hpm_ovf_pending), 32'd0);
    chk("reset_mcycle", csr_rd_data, 32'd0);
    drive(12'hB00, 1'b0, 1'b0, '0, PRV_M);
    #1 chk("idle_not_illegal", 32'(csr_illegal), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run = 1'b1;
    repeat (10) @(negedge clk);
    rd_chk(12'hB00, PRV_M, 32'd10, "mcycle_after_10");
    rd_chk(12'hB02, PRV_M, 32'd0, "minstret_idle");

    wr_m(12'hB80, 32'h0);
    wr_m(12'hB00, 32'hFFFF_FFFF);
    rd_chk(12'hB00, PRV_M, 32'hFFFF_FFFF, "mcycle_lo_max");
    rd_chk(12'hB00, PRV_M, 32'h0, "carry_lo");
    rd_chk(12'hB80, PRV_M, 32'h1, "carry_hi");

    wr_m(12'h323, 32'h1);
    wr_m(12'hB03, 32'hFFFF_FFFF);
    wr_m(12'hB83, 32'hFFFF_FFFF);
    rd_chk(12'hB83, PRV_M, 32'hFF, "hpm3_hi_trunc");
    drive(12'h000, 1'b0, 1'b0, '0, PRV_M);
    hpm_events = NE'(1);
    @(negedge clk);
    hpm_events = '0;
    drive(12'hB03, 1'b1, 1'b0, '0, PRV_M);
    #1;
    chk("hpm3_wrap_lo", csr_rd_data, 32'h0);
    chk("ovf_pending", 32'(hpm_ovf_pending), 32'd1);
    @(negedge clk);
    rd_chk(12'hB83, PRV_M, 32'h0, "hpm3_wrap_hi");
    rd_chk(12'h323, PRV_M, 32'h8000_0001, "mhpmevent3_of");

    wr_m(12'hB03, 32'hFFFF_FFFF);
    wr_m(12'hB83, 32'hFF);
    wr_m(12'h323, 32'h1);
    drive(12'h323, 1'b0, 1'b1, 32'h1, PRV_M);
    #1 chk("of_cleared", 32'(hpm_ovf_pending), 32'd0);
    hpm_events = NE'(1);
    @(negedge clk);
    hpm_events = '0;
    rd_chk(12'h323, PRV_M, 32'h8000_0001, "of_wrap_wins");

    wr_m(12'h320, 32'hFFFF_FFFF);
    rd_chk(12'h320, PRV_M, 32'h7D, "inhibit_mask");
    wr_m(12'hB00, 32'd100);
    drive(12'h000, 1'b0, 1'b0, '0, PRV_M);
    repeat (5) @(negedge clk);
    rd_chk(12'hB00, PRV_M, 32'd100, "mcycle_frozen");
    wr_m(12'h320, 32'h0);
    rd_chk(12'hB00, PRV_M, 32'd100, "mcycle_unfreeze");
    rd_chk(12'hB00, PRV_M, 32'd101, "mcycle_resumed");

    wr_m(12'h306, 32'h1);
    wr_m(12'h106, 32'h0);
    wr_m(12'hB00, 32'd500);
    acc_ill(12'hC00, 1'b0, PRV_U, 1'b1, "u_cycle_scen0");
    wr_m(12'h106, 32'h1);
    drive(12'hC00, 1'b1, 1'b0, '0, PRV_U);
    #1;
    chk("u_cycle_legal", 32'(csr_illegal), 32'd0);
    chk("u_cycle_data", csr_rd_data, 32'd502);
    @(negedge clk);
    acc_ill(12'h106, 1'b0, PRV_S, 1'b0, "s_scounteren");
    acc_ill(12'h106, 1'b0, PRV_U, 1'b1, "u_scounteren");
    acc_ill(12'hB00, 1'b0, PRV_S, 1'b1, "s_mcycle");
    acc_ill(12'hC02, 1'b0, PRV_U, 1'b1, "u_instret_off");
    acc_ill(12'h306, 1'b1, PRV_S, 1'b1, "s_wr_mcounteren");
    rd_chk(12'h306, PRV_M, 32'h1, "mcounteren_kept");
    event_retire = 1'b0;
    acc_ill(12'hC02, 1'b1, PRV_M, 1'b1, "m_wr_instret");
    rd_chk(12'hB02, PRV_M, 32'h0, "minstret_unchanged");
    drive(12'hB1F, 1'b0, 1'b1, 32'hDEAD_BEEF, PRV_M);
    #1;
    chk("unimpl_not_illegal", 32'(csr_illegal), 32'd0);
    chk("unimpl_hit", 32'(csr_hit), 32'd1);
    @(negedge clk);
    rd_chk(12'hB1F, PRV_M, 32'h0, "unimpl_reads_0");
    drive(12'h300, 1'b1, 1'b0, '0, PRV_U);
    #1;
    chk("miss_hit", 32'(csr_hit), 32'd0);
    chk("miss_illegal", 32'(csr_illegal), 32'd0);

    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      r = int'($urandom % 8);
      if (r < 2) d = 32'hFFFF_FFFF;
      else if (r < 4)
        d = ($urandom % 11) | (($urandom % 2) != 0 ? 32'h8000_0000 : 32'h0);
      else d = $urandom;
      r = int'($urandom % 4);
      drive(ADDRS[$urandom % 28], ($urandom % 2) != 0,
            ($urandom % 3) == 0, d,
            (r == 0) ? PRV_U : (r == 1) ? PRV_S : PRV_M);
      event_retire = ($urandom % 2) != 0;
      hpm_events = NE'($urandom & $urandom);
      if (i == 2000) begin
        #3 rst_n = 1'b0;
        m_reset();
        drive(12'hB00, 1'b1, 1'b0, '0, PRV_M);
        #1;
        chk("midrun_reset_cnt", csr_rd_data, 32'h0);
        chk("midrun_reset_ovf", 32'(hpm_ovf_pending), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
      end
    end
    @(negedge clk);
    drive(12'h000, 1'b0, 1'b0, '0, PRV_M);
    @(negedge clk);
    #3 run = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
